// File: rtl/pwm_audio_sample_scheduler.sv
// Stereo sample FIFO feeding the PWM output stage at a fixed sample rate.
// Duty values change only on sample-period boundaries; handles priming, underrun and muted idle.
module pwm_audio_sample_scheduler #(
  parameter int               WIDTH       = 8,
  parameter int               FIFO_DEPTH  = 16,
  parameter int               PERIOD      = 256,
  parameter int               PRIME_LEVEL = 4,
  parameter logic [WIDTH-1:0] MUTE_VALUE  = '0
) (
  input  logic                          clk,
  input  logic                          aclr,
  input  logic                          enable,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_left,
  input  logic [WIDTH-1:0]              in_right,
  output logic [WIDTH-1:0]              left_top,
  output logic [WIDTH-1:0]              right_top,
  output logic                          sample_tick,
  output logic                          running,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underrun,
  input  logic                          clear_underrun
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(PERIOD);
  localparam logic [LW-1:0] DEPTH_L  = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] PRIME_L  = LW'(PRIME_LEVEL);
  localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]          level_q, level_d;
  logic [WIDTH-1:0]       left_q, left_d;
  logic [WIDTH-1:0]       right_q, right_d;
  logic                   underrun_q, underrun_d;
  logic [2*WIDTH-1:0]     mem_q [FIFO_DEPTH];

  logic push;
  logic pop;
  logic tick;
  logic set_underrun;

  assign in_ready = (level_q < DEPTH_L);
  assign push     = in_valid && in_ready;
  assign tick     = (state_q == S_RUN) && (cnt_q == CNT_LAST);

  // Sequencer: period counter, playback state and duty-value loading on tick edges.
  always_comb begin
    state_d      = state_q;
    cnt_d        = '0;
    pop          = 1'b0;
    set_underrun = 1'b0;
    left_d       = left_q;
    right_d      = right_q;
    case (state_q)
      S_IDLE: begin
        if (enable && (level_q >= PRIME_L)) state_d = S_RUN;
      end
      S_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (tick) begin
          cnt_d = '0;
          if (!enable) begin
            state_d = S_IDLE;
            left_d  = MUTE_VALUE;
            right_d = MUTE_VALUE;
          end else if (level_q != '0) begin
            pop               = 1'b1;
            {left_d, right_d} = mem_q[rd_ptr_q];
          end else begin
            set_underrun = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Occupancy uses the pre-edge level, so a pop on empty never sees a same-edge push.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    underrun_d = underrun_q;
    if (set_underrun)        underrun_d = 1'b1;
    else if (clear_underrun) underrun_d = 1'b0;
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      left_q     <= MUTE_VALUE;
      right_q    <= MUTE_VALUE;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      left_q     <= left_d;
      right_q    <= right_d;
      underrun_q <= underrun_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_left, in_right};
  end

  assign left_top    = left_q;
  assign right_top   = right_q;
  assign sample_tick = tick;
  assign running     = (state_q == S_RUN);
  assign fifo_level  = level_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_pwm_audio_sample_scheduler.sv
// Bench for pwm_audio_sample_scheduler: directed vector table, corner sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_pwm_audio_sample_scheduler;

  localparam int WIDTH  = 8;
  localparam int DEPTH  = 16;
  localparam int PERIOD = 8;
  localparam int PRIME  = 4;
  localparam logic [7:0] MUTE = 8'd0;

  logic       clk = 1'b0;
  logic       aclr = 1'b0;
  logic       enable = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_left = '0;
  logic [7:0] in_right = '0;
  logic [7:0] left_top, right_top;
  logic       sample_tick, running, underrun;
  logic       clear_underrun = 1'b0;
  logic [4:0] fifo_level;

  int tests = 0;
  int fails = 0;

  pwm_audio_sample_scheduler #(
    .WIDTH(WIDTH), .FIFO_DEPTH(DEPTH), .PERIOD(PERIOD),
    .PRIME_LEVEL(PRIME), .MUTE_VALUE(MUTE)
  ) dut (
    .clk(clk), .aclr(aclr), .enable(enable), .in_valid(in_valid), .in_ready(in_ready),
    .in_left(in_left), .in_right(in_right), .left_top(left_top), .right_top(right_top),
    .sample_tick(sample_tick), .running(running), .fifo_level(fifo_level),
    .underrun(underrun), .clear_underrun(clear_underrun)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of pairs plus playback bit and sample phase.
  logic [15:0] m_q[$];
  bit          m_run;
  int          m_phase;
  logic [7:0]  m_left, m_right;
  bit          m_und;

  function automatic bit m_tick();
    return m_run && (m_phase == PERIOD - 1);
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_run = 0; m_phase = 0; m_left = MUTE; m_right = MUTE; m_und = 0;
  endtask

  task automatic model_edge(input bit en, input bit v, input logic [7:0] l,
                            input logic [7:0] r, input bit clr);
    bit tk;
    bit ready;
    bit set;
    int sz;
    tk = m_tick(); sz = m_q.size(); ready = (sz < DEPTH); set = 0;
    if (m_run) begin
      if (tk) begin
        if (!en) begin
          m_run = 0; m_left = MUTE; m_right = MUTE;
        end else if (sz > 0) begin
          {m_left, m_right} = m_q.pop_front();
        end else begin
          set = 1;
        end
      end
      m_phase = m_run ? (m_phase + 1) % PERIOD : 0;
    end else if (en && sz >= PRIME) begin
      m_run = 1; m_phase = 0;
    end
    if (v && ready) m_q.push_back({l, r});
    if (set) m_und = 1;
    else if (clr) m_und = 0;
  endtask

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("left_top", int'(left_top), int'(m_left));
    check("right_top", int'(right_top), int'(m_right));
    check("sample_tick", int'(sample_tick), int'(m_tick()));
    check("running", int'(running), int'(m_run));
    check("fifo_level", int'(fifo_level), m_q.size());
    check("underrun", int'(underrun), int'(m_und));
    check("in_ready", int'(in_ready), int'(m_q.size() < DEPTH));
  endtask

  // Drive one cycle's inputs, take the edge, check at the following negedge.
  task automatic step(input bit en, input bit v, input logic [7:0] l,
                      input logic [7:0] r, input bit clr);
    enable = en; in_valid = v; in_left = l; in_right = r; clear_underrun = clr;
    @(posedge clk);
    model_edge(en, v, l, r, clr);
    @(negedge clk);
    check_model();
  endtask

  task automatic run(input int n, input bit en);
    repeat (n) step(en, 1'b0, 8'd0, 8'd0, 1'b0);
  endtask

  // Asynchronous reset asserted between edges; values must appear before any clock edge.
  task automatic do_reset();
    @(negedge clk);
    #2 aclr = 1'b1;
    enable = 1'b0; in_valid = 1'b0; clear_underrun = 1'b0;
    #1;
    check("rst_left", int'(left_top), 0);
    check("rst_right", int'(right_top), 0);
    check("rst_tick", int'(sample_tick), 0);
    check("rst_running", int'(running), 0);
    check("rst_level", int'(fifo_level), 0);
    check("rst_underrun", int'(underrun), 0);
    check("rst_in_ready", int'(in_ready), 1);
    model_reset();
    @(negedge clk);
    aclr = 1'b0;
    check_model();
  endtask

  task automatic push4();
    step(0, 1, 8'd10, 8'd20, 0);
    step(0, 1, 8'd30, 8'd40, 0);
    step(0, 1, 8'd50, 8'd60, 0);
    step(0, 1, 8'd70, 8'd80, 0);
  endtask

  typedef struct {
    bit en; bit v; logic [7:0] l; logic [7:0] r; bit clr; int n;
    int el; int er; bit etick; bit erun; int elev; bit eund;
  } vec_t;

  vec_t tbl[15];

  initial begin
    // Prime, play, run dry into underrun, clear it, then disable at a tick.
    tbl[0]  = '{1'b0, 1'b1, 8'd10, 8'd20, 1'b0, 1,  0,  0, 1'b0, 1'b0, 1, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 8'd30, 8'd40, 1'b0, 1,  0,  0, 1'b0, 1'b0, 2, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 8'd50, 8'd60, 1'b0, 1,  0,  0, 1'b0, 1'b0, 3, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 8'd70, 8'd80, 1'b0, 1,  0,  0, 1'b0, 1'b0, 4, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 8'd0,  8'd0,  1'b0, 1,  0,  0, 1'b0, 1'b1, 4, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 8'd0,  8'd0,  1'b0, 7,  0,  0, 1'b1, 1'b1, 4, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 8'd0,  8'd0,  1'b0, 1, 10, 20, 1'b0, 1'b1, 3, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 8'd0,  8'd0,  1'b0, 8, 30, 40, 1'b0, 1'b1, 2, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 8'd0,  8'd0,  1'b0, 8, 50, 60, 1'b0, 1'b1, 1, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 8'd0,  8'd0,  1'b0, 8, 70, 80, 1'b0, 1'b1, 0, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 8'd0,  8'd0,  1'b0, 7, 70, 80, 1'b1, 1'b1, 0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 8'd0,  8'd0,  1'b0, 1, 70, 80, 1'b0, 1'b1, 0, 1'b1};
    tbl[12] = '{1'b1, 1'b0, 8'd0,  8'd0,  1'b1, 1, 70, 80, 1'b0, 1'b1, 0, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 8'd0,  8'd0,  1'b0, 6, 70, 80, 1'b1, 1'b1, 0, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 8'd0,  8'd0,  1'b0, 1,  0,  0, 1'b0, 1'b0, 0, 1'b0};

    model_reset();
    do_reset();

    for (int i = 0; i < 15; i++) begin
      repeat (tbl[i].n) step(tbl[i].en, tbl[i].v, tbl[i].l, tbl[i].r, tbl[i].clr);
      check($sformatf("vec%0d_left", i), int'(left_top), tbl[i].el);
      check($sformatf("vec%0d_right", i), int'(right_top), tbl[i].er);
      check($sformatf("vec%0d_tick", i), int'(sample_tick), int'(tbl[i].etick));
      check($sformatf("vec%0d_running", i), int'(running), int'(tbl[i].erun));
      check($sformatf("vec%0d_level", i), int'(fifo_level), tbl[i].elev);
      check($sformatf("vec%0d_underrun", i), int'(underrun), int'(tbl[i].eund));
    end

    // Backpressure: 20 offered, 16 accepted, popped back in order.
    do_reset();
    for (int i = 0; i < 20; i++) step(0, 1, 8'(i), 8'(8'hA0 + i), 0);
    check("bp_level", int'(fifo_level), 16);
    check("bp_in_ready", int'(in_ready), 0);
    step(1, 0, 8'd0, 8'd0, 0);
    for (int k = 0; k < 16; k++) begin
      run(8, 1);
      check($sformatf("bp_pop%0d_left", k), int'(left_top), k);
      check($sformatf("bp_pop%0d_right", k), int'(right_top), 8'hA0 + k);
    end
    check("bp_drained", int'(fifo_level), 0);

    // Disable mid-period, then a cancelled disable.
    do_reset();
    push4();
    step(1, 0, 8'd0, 8'd0, 0);
    run(8, 1);
    check("dis_first_left", int'(left_top), 10);
    run(3, 1);
    run(4, 0);
    check("dis_hold_left", int'(left_top), 10);
    check("dis_hold_right", int'(right_top), 20);
    check("dis_hold_run", int'(running), 1);
    step(0, 0, 8'd0, 8'd0, 0);
    check("dis_mute_left", int'(left_top), 0);
    check("dis_mute_right", int'(right_top), 0);
    check("dis_running", int'(running), 0);
    check("dis_no_pop", int'(fifo_level), 3);
    check("dis_no_underrun", int'(underrun), 0);
    step(0, 1, 8'd90, 8'd91, 0);
    step(1, 0, 8'd0, 8'd0, 0);
    run(3, 1);
    run(2, 0);
    run(2, 1);
    step(1, 0, 8'd0, 8'd0, 0);
    check("cancel_running", int'(running), 1);
    check("cancel_left", int'(left_top), 30);
    check("cancel_level", int'(fifo_level), 3);

    // Push and pop on the same tick edge, at level 1 and at level 0.
    do_reset();
    push4();
    step(1, 0, 8'd0, 8'd0, 0);
    run(24, 1);
    run(7, 1);
    check("pp1_tick", int'(sample_tick), 1);
    check("pp1_level_before", int'(fifo_level), 1);
    step(1, 1, 8'd99, 8'd98, 0);
    check("pp1_level", int'(fifo_level), 1);
    check("pp1_left", int'(left_top), 70);
    check("pp1_right", int'(right_top), 80);
    run(8, 1);
    check("pp0_left_before", int'(left_top), 99);
    check("pp0_level_before", int'(fifo_level), 0);
    run(7, 1);
    step(1, 1, 8'd55, 8'd56, 0);
    check("pp0_underrun", int'(underrun), 1);
    check("pp0_level", int'(fifo_level), 1);
    check("pp0_left_hold", int'(left_top), 99);
    run(8, 1);
    check("pp0_retained_left", int'(left_top), 55);
    check("pp0_retained_right", int'(right_top), 56);

    // Randomized traffic against the model, varying producer rate.
    do_reset();
    for (int seg = 0; seg < 6; seg++) begin
      int prob;
      prob = (seg % 3 == 0) ? 10 : ((seg % 3 == 1) ? 40 : 90);
      repeat (400) begin
        step($urandom_range(0, 99) < 90, $urandom_range(0, 99) < prob,
             8'($urandom), 8'($urandom), $urandom_range(0, 31) == 0);
      end
    end

    // Mid-stream asynchronous reset.
    do_reset();
    run(4, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
